i2c_addr_unit: RTL and testbench

- Address-phase serializer for the I2C master datapath.
- On a one-cycle `go` strobe it captures a 7-bit slave address, appends a fixed R/W bit, and shifts the 8-bit address byte out MSB-first on `oSDA`.
- Advances one bit per clock while the bit-enable `abit` is high.
- Sits between the master control FSM, which issues `go` and `abit`, and the SDA pad driver. `oSDA` idles high, matching I2C bus idle.

---
 rtl/i2c_addr_unit.sv | 95 +++++++++
 tb/tb_i2c_addr_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_addr_unit.sv
// I2C address-phase serializer: captures a 7-bit slave address plus R/W bit on go
// and shifts the byte out MSB-first on oSDA, one bit per abit-qualified clock.
module i2c_addr_unit #(
   parameter logic        RW_BIT = 1'b0,
   parameter int unsigned NBITS  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       abit,
   input  logic       go,
   input  logic [6:0] addrIn,
   output logic       oSDA
);

   localparam int unsigned SH_W  = 8;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [SH_W-1:0]    sh_q, sh_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sda_q, sda_d;

   // State register; reset returns the line to bus-idle high
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
         sda_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         sda_q   <= sda_d;
      end
   end

   // Next-state and shift logic
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      sda_d   = sda_q;

      unique case (state_q)
         S_IDLE: begin
            sda_d = 1'b1;
            if (go) begin
               sh_d    = {addrIn, RW_BIT};
               cnt_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (abit) begin
               sda_d   = sh_q[SH_W-1];
               sh_d    = {sh_q[SH_W-2:0], 1'b0};
               cnt_d   = CNT_W'(1);
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // abit low is a pause: everything holds
            if (abit && (cnt_q < CNT_W'(NBITS))) begin
               sda_d = sh_q[SH_W-1];
               sh_d  = {sh_q[SH_W-2:0], 1'b0};
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q + CNT_W'(1) == CNT_W'(NBITS)) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (!abit) begin
               sda_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            sda_d   = 1'b1;
         end
      endcase
   end

   assign oSDA = sda_q;

endmodule

// File: tb/tb_i2c_addr_unit.sv
// Self-checking bench for i2c_addr_unit: directed vector table, hand sequences for
// reset/R/W corners, and randomized traffic against a bit-queue reference model.
module tb_i2c_addr_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       abit;
   logic       go;
   logic [6:0] addrIn;
   logic       sda_wr;
   logic       sda_rd;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   i2c_addr_unit #(.RW_BIT(1'b0), .NBITS(8)) u_wr (
      .clk(clk), .rst(rst), .abit(abit), .go(go), .addrIn(addrIn), .oSDA(sda_wr)
   );

   i2c_addr_unit #(.RW_BIT(1'b1), .NBITS(8)) u_rd (
      .clk(clk), .rst(rst), .abit(abit), .go(go), .addrIn(addrIn), .oSDA(sda_rd)
   );

   // Reference model: a transfer is a queue of the 8 bits still to be sent.
   // Entry value 2 stands for the R/W bit, resolved per instance.
   int   mq[$];
   bit   m_busy;
   logic m_exp_wr, m_exp_rd;

   task automatic model_reset();
      mq.delete();
      m_busy   = 1'b0;
      m_exp_wr = 1'b1;
      m_exp_rd = 1'b1;
   endtask

   task automatic model_step(input logic g, input logic a, input logic [6:0] ad);
      int v;
      if (!m_busy) begin
         if (g) begin
            mq.delete();
            for (int i = 6; i >= 0; i--) mq.push_back(int'((ad >> i) & 7'd1));
            mq.push_back(2);
            m_busy = 1'b1;
         end
      end else if (mq.size() > 0) begin
         if (a) begin
            v = mq.pop_front();
            m_exp_wr = (v == 2) ? 1'b0 : v[0];
            m_exp_rd = (v == 2) ? 1'b1 : v[0];
         end
      end else if (!a) begin
         m_busy   = 1'b0;
         m_exp_wr = 1'b1;
         m_exp_rd = 1'b1;
      end
   endtask

   task automatic chk(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // One clock: drive at negedge, update model at posedge, sample 1 time unit later
   task automatic step(input logic g, input logic a, input logic [6:0] ad);
      @(negedge clk);
      go = g; abit = a; addrIn = ad;
      @(posedge clk);
      model_step(g, a, ad);
      #1;
      chk("model_wr", sda_wr, m_exp_wr);
      chk("model_rd", sda_rd, m_exp_rd);
   endtask

   // Reset asserted between edges; output must go high without waiting for a clock
   task automatic async_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      model_reset();
      #1;
      chk("async_rst_wr", sda_wr, 1'b1);
      chk("async_rst_rd", sda_rd, 1'b1);
      @(negedge clk);
      rst = 1'b1;
   endtask

   typedef struct {
      logic       go;
      logic       abit;
      logic [6:0] addr;
      logic       exp;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic g, input logic a, input logic [6:0] ad, input logic e);
      vec_t v;
      v.go = g; v.abit = a; v.addr = ad; v.exp = e;
      tbl.push_back(v);
   endfunction

   function automatic void add_bits(input logic [7:0] bits, input int n, input int first);
      for (int i = first; i < first + n; i++) add(1'b0, 1'b1, 7'h00, bits[7-i]);
   endfunction

   initial begin
      rst = 1'b0; go = 1'b0; abit = 1'b0; addrIn = '0;
      model_reset();

      // Basic transfer of 65 (1000001 + W)
      add(1'b1, 1'b0, 7'd65, 1'b1);
      add_bits(8'b1000_0010, 8, 0);
      add(1'b0, 1'b0, 7'h00, 1'b1);
      add(1'b0, 1'b0, 7'h00, 1'b1);
      // Pause mid-byte with 0x55
      add(1'b1, 1'b0, 7'h55, 1'b1);
      add_bits(8'b1010_1010, 3, 0);
      for (int i = 0; i < 4; i++) add(1'b0, 1'b0, 7'h00, 1'b1);
      add_bits(8'b1010_1010, 5, 3);
      add(1'b0, 1'b0, 7'h00, 1'b1);
      // go during shift of 0x7F with addrIn=0 is ignored
      add(1'b1, 1'b0, 7'h7F, 1'b1);
      add_bits(8'b1111_1110, 2, 0);
      add(1'b1, 1'b1, 7'h00, 1'b1);
      add_bits(8'b1111_1110, 5, 3);
      add(1'b0, 1'b0, 7'h00, 1'b1);
      // go and abit together in IDLE only load
      add(1'b1, 1'b1, 7'h40, 1'b1);
      add_bits(8'b1000_0000, 8, 0);
      add(1'b0, 1'b1, 7'h00, 1'b0);
      add(1'b0, 1'b0, 7'h00, 1'b1);

      // Reset held for two cycles
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("reset_wr", sda_wr, 1'b1);
         chk("reset_rd", sda_rd, 1'b1);
      end
      @(negedge clk);
      rst = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].go, tbl[i].abit, tbl[i].addr);
         chk($sformatf("vec%0d", i), sda_wr, tbl[i].exp);
      end

      // Read instance: all-zero address, R/W=1 held while abit stays high
      step(1'b1, 1'b0, 7'h00);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b1, 7'h00);
         chk("rd_addr_bit", sda_rd, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 7'h00);
         chk("rd_rw_hold", sda_rd, 1'b1);
      end
      step(1'b0, 1'b0, 7'h00);
      chk("rd_idle", sda_rd, 1'b1);

      // Asynchronous reset mid-SHIFT aborts; no bits resume after release
      step(1'b1, 1'b0, 7'h2A);
      step(1'b0, 1'b1, 7'h00);
      step(1'b0, 1'b1, 7'h00);
      async_reset();
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 7'h00);
         chk("post_rst_idle", sda_wr, 1'b1);
      end

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            async_reset();
         end else begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7, 7'($urandom));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
